// File: rtl/alu_wide_sequencer.sv
// rtl/alu_wide_sequencer.sv - multi-slice sequencer driving a narrow shared ALU for wide ops
module alu_wide_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [3:0]                    i_req_op,
    input  logic [DATA_WIDTH*WORDS-1:0]   i_req_a,
    input  logic [DATA_WIDTH*WORDS-1:0]   i_req_b,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [DATA_WIDTH*WORDS-1:0]   o_rsp_result,
    output logic [3:0]                    o_rsp_status,
    output logic [3:0]                    o_alu_control,
    output logic [DATA_WIDTH-1:0]         o_alu_a,
    output logic [DATA_WIDTH-1:0]         o_alu_b,
    output logic [3:0]                    o_alu_si,
    input  logic [DATA_WIDTH-1:0]         i_alu_out,
    input  logic [3:0]                    i_alu_so
);

    // ALU operation codes shared with the ALU
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_XNOR = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_NAND = 4'd7;

    // Status bit positions: {V,N,Z,C}
    localparam int STATUS_C_BIT = 0;
    localparam int STATUS_Z_BIT = 1;
    localparam int STATUS_N_BIT = 2;
    localparam int STATUS_V_BIT = 3;

    localparam int W  = DATA_WIDTH * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_op;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [KW-1:0]       r_k;
    logic                r_carry;
    logic                r_zacc;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [W-1:0]        r_result;
    logic [3:0]          r_status;

    logic [DATA_WIDTH-1:0] w_a_slice;
    logic [DATA_WIDTH-1:0] w_b_slice;
    logic                  w_last;
    logic                  w_req_supported;
    logic                  w_op_is_logic;
    logic                  w_slice_z;

    assign w_a_slice       = r_a[r_k*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_slice       = r_b[r_k*DATA_WIDTH +: DATA_WIDTH];
    assign w_last          = (r_k == KW'(WORDS - 1));
    assign w_req_supported = (i_req_op <= ALU_NAND);
    assign w_op_is_logic   = (r_op != ALU_ADD) && (r_op != ALU_SUB);
    assign w_slice_z       = r_zacc & i_alu_so[STATUS_Z_BIT];

    assign o_req_ready  = r_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_result;
    assign o_rsp_status = r_status;

    // Present the current slice to the ALU while running; idle drive is a harmless AND of zeros
    always_comb begin
        o_alu_control = ALU_AND;
        o_alu_a       = '0;
        o_alu_b       = '0;
        o_alu_si      = '0;
        if (r_state == S_RUN) begin
            o_alu_a = w_a_slice;
            case (r_op)
                ALU_ADD: begin
                    o_alu_control              = ALU_ADD;
                    o_alu_b                    = w_b_slice;
                    o_alu_si[STATUS_C_BIT]     = r_carry;
                end
                ALU_SUB: begin
                    // A - B done as A + ~B + 1; the +1 is the carry preset at accept
                    o_alu_control              = ALU_ADD;
                    o_alu_b                    = ~w_b_slice;
                    o_alu_si[STATUS_C_BIT]     = r_carry;
                end
                default: begin
                    o_alu_control              = r_op;
                    o_alu_b                    = w_b_slice;
                end
            endcase
        end
    end

    // Sequencer FSM: accept, walk slices LS first with carry chaining, hold response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_op        <= ALU_AND;
            r_a         <= '0;
            r_b         <= '0;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_zacc      <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_status    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_op        <= i_req_op;
                        r_a         <= i_req_a;
                        r_b         <= i_req_b;
                        r_k         <= '0;
                        r_carry     <= (i_req_op == ALU_SUB);
                        r_zacc      <= 1'b1;
                        r_result    <= '0;
                        r_status    <= '0;
                        r_req_ready <= 1'b0;
                        if (w_req_supported) begin
                            r_state <= S_RUN;
                        end else begin
                            // Unknown op: answer immediately with zero result and status
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_result[r_k*DATA_WIDTH +: DATA_WIDTH] <= i_alu_out;
                    r_carry <= i_alu_so[STATUS_C_BIT];
                    r_zacc  <= w_slice_z;
                    if (w_last) begin
                        r_status[STATUS_V_BIT] <= w_op_is_logic ? 1'b0 : i_alu_so[STATUS_V_BIT];
                        r_status[STATUS_N_BIT] <= i_alu_so[STATUS_N_BIT];
                        r_status[STATUS_Z_BIT] <= w_slice_z;
                        r_status[STATUS_C_BIT] <= w_op_is_logic ? 1'b0 : i_alu_so[STATUS_C_BIT];
                        r_rsp_valid            <= 1'b1;
                        r_state                <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb/tb_alu_wide_sequencer.sv - scoreboard bench for alu_wide_sequencer with a behavioural ALU
module tb_alu_wide_sequencer;

    localparam int DW    = 32;
    localparam int WORDS = 2;
    localparam int W     = DW * WORDS;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [3:0]     req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_result;
    logic [3:0]     rsp_status;
    logic [3:0]     alu_control;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [3:0]     alu_si;
    logic [DW-1:0]  alu_out;
    logic [3:0]     alu_so;
    logic [DW:0]    alu_sum;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   st;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_wide_sequencer #(.DATA_WIDTH(DW), .WORDS(WORDS)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op      (req_op),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_result  (rsp_result),
        .o_rsp_status  (rsp_status),
        .o_alu_control (alu_control),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_si      (alu_si),
        .i_alu_out     (alu_out),
        .i_alu_so      (alu_so)
    );

    // Behavioural single-slice ALU, status {V,N,Z,C}
    always_comb begin
        alu_sum = '0;
        alu_out = '0;
        alu_so  = '0;
        case (alu_control)
            OP_ADD: begin
                alu_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_si[0]};
                alu_out   = alu_sum[DW-1:0];
                alu_so[0] = alu_sum[DW];
                alu_so[3] = (alu_a[DW-1] == alu_b[DW-1]) && (alu_out[DW-1] != alu_a[DW-1]);
            end
            OP_SUB:  alu_out = alu_a - alu_b;
            OP_AND:  alu_out = alu_a & alu_b;
            OP_OR:   alu_out = alu_a | alu_b;
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_XNOR: alu_out = ~(alu_a ^ alu_b);
            OP_NOR:  alu_out = ~(alu_a | alu_b);
            OP_NAND: alu_out = ~(alu_a & alu_b);
            default: alu_out = '0;
        endcase
        alu_so[2] = alu_out[DW-1];
        alu_so[1] = (alu_out == '0);
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Full-width reference model
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic [3:0] st);
        logic [W:0] s;
        logic v, c;
        v = 1'b0; c = 1'b0; res = '0; s = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                res = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                res = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_NOR:  res = ~(a | b);
            OP_NAND: res = ~(a & b);
            default: res = '0;
        endcase
        if (op > OP_NAND) st = 4'b0000;
        else st = {v, res[W-1], (res == '0), c};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eres, input logic [3:0] est,
                          input int stall);
        exp_t e;
        exp_t got_e;
        int t;
        int lat;
        logic [W-1:0] held;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        e.res = eres;
        e.st  = est;
        e.lat = (op > OP_NAND) ? 1 : WORDS + 1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got_e = exp_q.pop_front();
        check_eq({tag, "_lat"}, W'(lat), W'(got_e.lat));
        check_eq({tag, "_res"}, rsp_result, got_e.res);
        check_eq({tag, "_st"}, W'(rsp_status), W'(got_e.st));
        held = rsp_result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, W'(rsp_valid), W'(1));
            check_eq({tag, "_hold_res"}, rsp_result, held);
            check_eq({tag, "_hold_rdy"}, W'(req_ready), W'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_post_valid"}, W'(rsp_valid), W'(0));
        check_eq({tag, "_post_rdy"}, W'(req_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic [3:0]   es, op;
        logic         seen_valid;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", W'(req_ready), W'(1));
        check_eq("rst_rsp_valid", W'(rsp_valid), W'(0));
        check_eq("rst_result", rsp_result, '0);
        check_eq("rst_status", W'(rsp_status), W'(0));
        check_eq("rst_alu_ctl", W'(alu_control), W'(OP_AND));
        check_eq("rst_alu_ab", W'({alu_a, alu_b}), '0);
        check_eq("rst_alu_si", W'(alu_si), W'(0));
        rst = 1'b0;

        run_op("add_carry", OP_ADD, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000, 4'b0000, 0);
        run_op("sub_borrow", OP_SUB, 64'h00000001_00000000, 64'h1, 64'h00000000_FFFFFFFF, 4'b0001, 0);
        run_op("sub_zero", OP_SUB, 64'd5, 64'd5, 64'h0, 4'b0011, 0);
        run_op("add_ovf", OP_ADD, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 4'b1100, 0);
        run_op("sub_neg", OP_SUB, 64'h0, 64'h1, 64'hFFFFFFFF_FFFFFFFF, 4'b0100, 0);
        run_op("xor_stall", OP_XOR, 64'hDEADBEEF_12345678, 64'hDEADBEEF_12345678, 64'h0, 4'b0010, 5);
        run_op("bad_op", 4'hF, 64'h1234, 64'h5678, 64'h0, 4'b0000, 0);
        run_op("add_after_bad", OP_ADD, 64'd1, 64'd2, 64'd3, 4'b0000, 0);

        // Reset while the first slice is on the ALU
        @(negedge clk);
        req_op = OP_ADD; req_a = 64'd9; req_b = 64'd9; req_valid = 1'b1;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        check_eq("mid_run_alu_ctl_pre", W'(alu_a), W'(9));
        rst = 1'b1;
        #1;
        check_eq("mid_run_alu_ctl", W'(alu_control), W'(OP_AND));
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_valid = 1'b1;
        end
        check_eq("mid_run_no_rsp", W'(seen_valid), W'(0));
        check_eq("mid_run_rdy", W'(req_ready), W'(1));
        run_op("add_after_rst", OP_ADD, 64'd2, 64'd3, 64'd5, 4'b0000, 0);

        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 8));
            ra = {$urandom, $urandom};
            rb = (i % 4 == 0) ? ra : {$urandom, $urandom};
            model(op, ra, rb, er, es);
            run_op($sformatf("rnd%0d", i), op, ra, rb, er, es, i % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
